// File: rtl/vpg_pkg.sv
// Video pattern generator shared definitions.
// Holds the pattern mode encoding, the colour-bar table and the default
// active-area geometry. The timing generator imports the same package.
package vpg_pkg;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    GRADIENT = 2'd2,
    SOLID    = 2'd3
  } mode_e;

  localparam int unsigned H_ACTIVE_DEF = 1920;
  localparam int unsigned V_ACTIVE_DEF = 1080;

  // Bar colours as {r,g,b} on/off bits, index 0 is the leftmost bar:
  // white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/vpg_pattern_gen_if.sv
// Pixel-stream bundle for the pattern generator.
// master: timing source driving coordinates/controls and receiving colour.
// slave : pattern generator side.
// Signals: h_count, v_count, de, frame_start, mode_sel, solid_rgb (to the
// generator); read_r, read_g, read_b, out_de (from the generator).
interface vpg_pattern_gen_if #(
  parameter int unsigned COUNT_W = 12,
  parameter int unsigned COLOR_W = 8
);
  logic [COUNT_W-1:0]   h_count;
  logic [COUNT_W-1:0]   v_count;
  logic                 de;
  logic                 frame_start;
  logic [1:0]           mode_sel;
  logic [3*COLOR_W-1:0] solid_rgb;
  logic [COLOR_W-1:0]   read_r;
  logic [COLOR_W-1:0]   read_g;
  logic [COLOR_W-1:0]   read_b;
  logic                 out_de;

  modport master (
    output h_count, v_count, de, frame_start, mode_sel, solid_rgb,
    input  read_r, read_g, read_b, out_de
  );

  modport slave (
    input  h_count, v_count, de, frame_start, mode_sel, solid_rgb,
    output read_r, read_g, read_b, out_de
  );
endinterface

// File: rtl/vpg_bar_index.sv
// Maps a pixel column to one of eight colour-bar indices.
// Ports: h_count (in)   - pixel column
//        bar_idx (out)  - 0..7 bar number
//        out_of_range (out) - column at or beyond 8*(H_ACTIVE/8)
// Thresholds k*(H_ACTIVE/8) are elaboration-time constants, so this is a
// set of comparators rather than a divider.
module vpg_bar_index #(
  parameter int unsigned COUNT_W  = 12,
  parameter int unsigned H_ACTIVE = 1920
) (
  input  logic [COUNT_W-1:0] h_count,
  output logic [2:0]         bar_idx,
  output logic               out_of_range
);
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  always_comb begin
    bar_idx      = '0;
    out_of_range = 1'b0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(h_count) >= k * BAR_W) bar_idx = 3'(k);
    end
    if (32'(h_count) >= 8 * BAR_W) out_of_range = 1'b1;
  end
endmodule

// File: rtl/vpg_pattern_gen.sv
// Video test-pattern generator: colour bars, checkerboard, gradient, solid.
// Two-stage pipeline: stage 1 captures de, coordinates and the active pattern
// selectors; stage 2 registers the colour. Outputs lag inputs by 2 cycles.
// Ports: clk, reset (async, active high); h_count, v_count, de, frame_start,
//        mode_sel, solid_rgb in; read_r, read_g, read_b, out_de out.
// Build option: define VPG_MARKER_EN to overlay corner alignment markers.
module vpg_pattern_gen
  import vpg_pkg::*;
#(
  parameter int unsigned COUNT_W    = 12,
  parameter int unsigned COLOR_W    = 8,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COUNT_W-1:0]   h_count,
  input  logic [COUNT_W-1:0]   v_count,
  input  logic                 de,
  input  logic                 frame_start,
  input  logic [1:0]           mode_sel,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [COLOR_W-1:0]   read_r,
  output logic [COLOR_W-1:0]   read_g,
  output logic [COLOR_W-1:0]   read_b,
  output logic                 out_de
);

  // Per-frame active selectors
  mode_e                act_mode_q,  act_mode_d;
  logic [3*COLOR_W-1:0] act_solid_q, act_solid_d;
  logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_d;

  // Stage 1
  logic                 s1_de_q,    s1_de_d;
  logic [COUNT_W-1:0]   s1_h_q,     s1_h_d;
  logic [COUNT_W-1:0]   s1_v_q,     s1_v_d;
  mode_e                s1_mode_q,  s1_mode_d;
  logic [FRAME_W-1:0]   s1_frame_q, s1_frame_d;
  logic [3*COLOR_W-1:0] s1_solid_q, s1_solid_d;

  // Stage 2
  logic [COLOR_W-1:0]   r_q, r_d;
  logic [COLOR_W-1:0]   g_q, g_d;
  logic [COLOR_W-1:0]   b_q, b_d;
  logic                 de2_q, de2_d;

  logic [2:0]           bar_idx;
  logic                 bar_oor;
  logic [2:0]           bar_bits;
  logic                 chk;
  logic                 in_range;

  vpg_bar_index #(
    .COUNT_W  (COUNT_W),
    .H_ACTIVE (H_ACTIVE)
  ) u_bar_index (
    .h_count      (s1_h_q),
    .bar_idx      (bar_idx),
    .out_of_range (bar_oor)
  );

  // Stage 1 samples the selectors before any frame_start update, so a pixel
  // coincident with frame_start still uses the previous mode and count.
  always_comb begin
    act_mode_d  = act_mode_q;
    act_solid_d = act_solid_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      act_mode_d  = mode_e'(mode_sel);
      act_solid_d = solid_rgb;
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
    s1_de_d    = de;
    s1_h_d     = h_count;
    s1_v_d     = v_count;
    s1_mode_d  = act_mode_q;
    s1_frame_d = frame_cnt_q;
    s1_solid_d = act_solid_q;
  end

  always_comb begin
    r_d      = '0;
    g_d      = '0;
    b_d      = '0;
    de2_d    = s1_de_q;
    bar_bits = BAR_RGB[bar_idx];
    chk      = s1_h_q[CHECK_LOG2] ^ s1_v_q[CHECK_LOG2] ^ s1_frame_q[0];
    in_range = (32'(s1_h_q) < H_ACTIVE) && (32'(s1_v_q) < V_ACTIVE);

    case (s1_mode_q)
      BARS: begin
        if (!bar_oor) begin
          r_d = {COLOR_W{bar_bits[2]}};
          g_d = {COLOR_W{bar_bits[1]}};
          b_d = {COLOR_W{bar_bits[0]}};
        end
      end
      CHECKER: begin
        r_d = {COLOR_W{~chk}};
        g_d = {COLOR_W{~chk}};
        b_d = {COLOR_W{~chk}};
      end
      GRADIENT: begin
        r_d = COLOR_W'(s1_h_q) + COLOR_W'(s1_frame_q);
        g_d = COLOR_W'(s1_v_q);
        b_d = COLOR_W'(s1_frame_q);
      end
      SOLID: begin
        r_d = s1_solid_q[3*COLOR_W-1 -: COLOR_W];
        g_d = s1_solid_q[2*COLOR_W-1 -: COLOR_W];
        b_d = s1_solid_q[COLOR_W-1:0];
      end
      default: ;
    endcase

`ifdef VPG_MARKER_EN
    if (s1_h_q == '0 && s1_v_q == '0) begin
      r_d = '1; g_d = '0; b_d = '0;
    end else if (32'(s1_h_q) == H_ACTIVE - 1 && s1_v_q == '0) begin
      r_d = '0; g_d = '1; b_d = '0;
    end else if (s1_h_q == '0 && 32'(s1_v_q) == V_ACTIVE - 1) begin
      r_d = '0; g_d = '0; b_d = '1;
    end else if (32'(s1_h_q) == H_ACTIVE - 1 && 32'(s1_v_q) == V_ACTIVE - 1) begin
      r_d = '1; g_d = '1; b_d = '0;
    end
`endif

    // Blanking and out-of-area pixels are forced black after any override.
    if (!(s1_de_q && in_range)) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_mode_q  <= BARS;
      act_solid_q <= '0;
      frame_cnt_q <= '0;
      s1_de_q     <= 1'b0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      s1_mode_q   <= BARS;
      s1_frame_q  <= '0;
      s1_solid_q  <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      de2_q       <= 1'b0;
    end else begin
      act_mode_q  <= act_mode_d;
      act_solid_q <= act_solid_d;
      frame_cnt_q <= frame_cnt_d;
      s1_de_q     <= s1_de_d;
      s1_h_q      <= s1_h_d;
      s1_v_q      <= s1_v_d;
      s1_mode_q   <= s1_mode_d;
      s1_frame_q  <= s1_frame_d;
      s1_solid_q  <= s1_solid_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      de2_q       <= de2_d;
    end
  end

  assign read_r = r_q;
  assign read_g = g_q;
  assign read_b = b_q;
  assign out_de = de2_q;

endmodule

// File: tb/tb_vpg_pattern_gen.sv
// Bench for vpg_pattern_gen: a behavioural reference computes each pixel's
// colour straight from the pattern rules; a 2-deep queue provides latency.
module tb_vpg_pattern_gen;
  localparam int COUNT_W = 12;
  localparam int COLOR_W = 8;
  localparam int HA      = 1920;
  localparam int VA      = 1080;
  localparam int CL      = 5;
  localparam int FW      = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vpg_pattern_gen_if #(.COUNT_W(COUNT_W), .COLOR_W(COLOR_W)) vif();

  vpg_pattern_gen #(
    .COUNT_W(COUNT_W), .COLOR_W(COLOR_W), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .CHECK_LOG2(CL), .FRAME_W(FW)
  ) dut (
    .clk(clk), .reset(reset),
    .h_count(vif.h_count), .v_count(vif.v_count), .de(vif.de),
    .frame_start(vif.frame_start), .mode_sel(vif.mode_sel),
    .solid_rgb(vif.solid_rgb),
    .read_r(vif.read_r), .read_g(vif.read_g), .read_b(vif.read_b),
    .out_de(vif.out_de)
  );

  int vectors = 0;
  int miscompares = 0;

  int          m_mode;
  int          m_frame;
  logic [23:0] m_solid;
  logic [24:0] pipe_q[$];

  function automatic logic [23:0] ref_rgb(input logic d, input int h, input int v,
                                          input int mode, input int frame,
                                          input logic [23:0] solid);
    int bar;
    if (!d || h >= HA || v >= VA) return 24'h0;
`ifdef VPG_MARKER_EN
    if (h == 0 && v == 0) return 24'hFF0000;
    if (h == HA-1 && v == 0) return 24'h00FF00;
    if (h == 0 && v == VA-1) return 24'h0000FF;
    if (h == HA-1 && v == VA-1) return 24'hFFFF00;
`endif
    case (mode)
      0: begin
        bar = h / (HA / 8);
        case (bar)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return ((((h >> CL) ^ (v >> CL) ^ frame) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      2: return {8'((h + frame) % 256), 8'(v % 256), 8'(frame % 256)};
      default: return solid;
    endcase
  endfunction

  task automatic compare(input string name, input logic [24:0] exp);
    logic [24:0] act;
    act = {vif.out_de, vif.read_r, vif.read_g, vif.read_b};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got de=%b rgb=%h, expected de=%b rgb=%h",
               name, $time, act[24], act[23:0], exp[24], exp[23:0]);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_frame = 0;
    m_solid = '0;
    pipe_q.delete();
    pipe_q.push_back('0);
  endtask

  // One pixel clock: drive, let the model consume the pixel at the edge,
  // then check the DUT on the falling edge.
  task automatic step(input logic d, input int h, input int v, input logic fs,
                      input int mode, input logic [23:0] solid);
    logic [24:0] exp;
    vif.de          = d;
    vif.h_count     = 12'(h);
    vif.v_count     = 12'(v);
    vif.frame_start = fs;
    vif.mode_sel    = 2'(mode);
    vif.solid_rgb   = solid;
    @(posedge clk);
    pipe_q.push_back({d, ref_rgb(d, h, v, m_mode, m_frame, m_solid)});
    if (fs) begin
      m_mode  = mode;
      m_solid = solid;
      m_frame = (m_frame + 1) % (1 << FW);
    end
    exp = pipe_q.pop_front();
    @(negedge clk);
    compare("model", exp);
  endtask

  task automatic idle(input int mode);
    step(1'b0, 0, 0, 1'b0, mode, 24'h0);
  endtask

  // Called at a falling edge, so reset rises between clock edges.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    compare("reset_async", 25'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare("reset_held", 25'h0);
    reset = 1'b0;
  endtask

  initial begin
    vif.de = 1'b0; vif.h_count = '0; vif.v_count = '0;
    vif.frame_start = 1'b0; vif.mode_sel = '0; vif.solid_rgb = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    compare("reset_state", 25'h0);
    model_reset();
    reset = 1'b0;

    // Colour bars and 2-cycle latency
    step(1'b0, 0, 0, 1'b1, 0, 24'h0);
    step(1'b1, 10, 0, 1'b0, 0, 24'h0);
    step(1'b1, 240, 0, 1'b0, 0, 24'h0);
    compare("bars_white", {1'b1, 24'hFFFFFF});
    idle(0);
    compare("bars_yellow", {1'b1, 24'hFFFF00});

    // Mode change without frame_start must not tear
    step(1'b1, 5, 1, 1'b0, 3, 24'h0);
    idle(3);
    compare("no_tear", {1'b1, 24'hFFFFFF});
    step(1'b0, 0, 0, 1'b1, 3, 24'h123456);
    step(1'b1, 5, 5, 1'b0, 3, 24'h0);
    idle(3);
    compare("solid_latched", {1'b1, 24'h123456});

    // Pixel coincident with frame_start keeps the old mode
    step(1'b1, 10, 10, 1'b1, 0, 24'h0);
    step(1'b1, 10, 10, 1'b0, 0, 24'h0);
    compare("fs_de_old_mode", {1'b1, 24'h123456});
    idle(0);
    compare("fs_de_new_mode", {1'b1, 24'hFFFFFF});

    // Gradient wrap with frame_cnt=5
    apply_reset();
    repeat (5) step(1'b0, 0, 0, 1'b1, 2, 24'h0);
    step(1'b1, 253, 7, 1'b0, 2, 24'h0);
    idle(2);
    compare("grad_wrap", {1'b1, 24'h020705});

    // Frame counter wrap
    apply_reset();
    repeat (255) step(1'b0, 0, 0, 1'b1, 2, 24'h0);
    step(1'b1, 10, 3, 1'b0, 2, 24'h0);
    idle(2);
    compare("frame_255", {1'b1, 24'h0903FF});
    step(1'b0, 0, 0, 1'b1, 2, 24'h0);
    step(1'b1, 10, 3, 1'b0, 2, 24'h0);
    idle(2);
    compare("frame_wrap0", {1'b1, 24'h0A0300});

    // Checkerboard inversion and out-of-range column
    apply_reset();
    step(1'b0, 0, 0, 1'b1, 1, 24'h0);
    step(1'b0, 0, 0, 1'b1, 1, 24'h0);
    step(1'b1, 32, 0, 1'b0, 1, 24'h0);
    idle(1);
    compare("chk_even", {1'b1, 24'h000000});
    step(1'b0, 0, 0, 1'b1, 1, 24'h0);
    step(1'b1, 32, 0, 1'b0, 1, 24'h0);
    idle(1);
    compare("chk_odd", {1'b1, 24'hFFFFFF});
    step(1'b1, 2000, 0, 1'b0, 1, 24'h0);
    idle(1);
    compare("h_out_of_range", {1'b1, 24'h000000});

    // Reset mid-frame with valid pixels in flight
    apply_reset();
    step(1'b0, 0, 0, 1'b1, 3, 24'hA5A5A5);
    step(1'b1, 100, 100, 1'b0, 3, 24'h0);
    step(1'b1, 101, 100, 1'b0, 3, 24'h0);
    compare("in_flight", {1'b1, 24'hA5A5A5});
    apply_reset();
    idle(3);
    compare("reset_release", 25'h0);
    idle(3);

    // Corner markers over solid grey
    step(1'b0, 0, 0, 1'b1, 3, 24'h808080);
    step(1'b1, 0, 0, 1'b0, 3, 24'h0);
    step(1'b1, HA-1, VA-1, 1'b0, 3, 24'h0);
`ifdef VPG_MARKER_EN
    compare("marker_origin", {1'b1, 24'hFF0000});
`else
    compare("marker_origin", {1'b1, 24'h808080});
`endif
    step(1'b1, 1, 0, 1'b0, 3, 24'h0);
`ifdef VPG_MARKER_EN
    compare("marker_far", {1'b1, 24'hFFFF00});
`else
    compare("marker_far", {1'b1, 24'h808080});
`endif
    idle(3);
    compare("marker_none", {1'b1, 24'h808080});

    // Randomised traffic, biased towards boundary columns/lines
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      int h, v, sel;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: h = 0;
        1: h = HA - 1;
        2: h = HA;
        3: h = 8 * (HA / 8) - 1;
        default: h = int'($urandom_range(0, 4095));
      endcase
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: v = 0;
        1: v = VA - 1;
        2: v = VA;
        default: v = int'($urandom_range(0, 1199));
      endcase
      step($urandom_range(0, 3) != 0, h, v, $urandom_range(0, 31) == 0,
           int'($urandom_range(0, 3)), 24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vpg_pattern_gen.md
VPG_PATTERN_GEN -- requirements
Module: vpg_pattern_gen

Interface
REQ-001 SHALL have parameters: COUNT_W, default 12, width of h_count/v_count.
REQ-002 SHALL have parameter COLOR_W, default 8, per-channel colour width.
REQ-003 SHALL have parameters H_ACTIVE, default 1920, and V_ACTIVE, default 1080, giving active pixels per line and lines per frame.
REQ-004 SHALL have parameter CHECK_LOG2, default 5, giving the checkerboard square size as 2^CHECK_LOG2 pixels.
REQ-005 SHALL have parameter FRAME_W, default 8, frame counter width.
REQ-006 SHALL use one clock and an asynchronous, active-high reset.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: pixel clock.
- reset, in, 1: asynchronous active-high reset.
- h_count, in, COUNT_W: current pixel column.
- v_count, in, COUNT_W: current line.
- de, in, 1: active-video qualifier.
- frame_start, in, 1: single-cycle pulse, once per frame, before the first active pixel.
- mode_sel, in, 2: requested pattern.
- solid_rgb, in, 3*COLOR_W: solid colour {r,g,b}.
- read_r, out, COLOR_W: red output.
- read_g, out, COLOR_W: green output.
- read_b, out, COLOR_W: blue output.
- out_de, out, 1: de delayed to align with the colour outputs.

Function
REQ-008 SHALL be a 2-stage pipeline:
- Stage 1 registers de, the coordinates and the pattern selectors.
- Stage 2 registers the colour.
- read_*/out_de SHALL reflect inputs from exactly 2 clk cycles earlier.
REQ-009 SHALL latch mode_sel and solid_rgb into active registers only on a cycle with frame_start=1. The new values SHALL apply from the following cycle, so mode changes never tear mid-frame.
REQ-010 SHALL keep an FRAME_W-bit frame counter:
- Increments on each frame_start.
- Wraps from 2^FRAME_W-1 to 0.
REQ-011 When frame_start and de are both 1 in the same cycle, that pixel SHALL use the previous mode and frame count.
REQ-012 Mode 0 (BARS) SHALL select among 8 vertical bars of width H_ACTIVE/8 (integer). Bar k is bounded by compile-time thresholds k*(H_ACTIVE/8).
REQ-013 Bar colours SHALL be, in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
REQ-014 Columns at or beyond 8*(H_ACTIVE/8) SHALL output black.
REQ-015 Mode 1 (CHECKER) SHALL output white when h_count[CHECK_LOG2] XOR v_count[CHECK_LOG2] XOR frame_cnt[0] is 0, otherwise black. The board inverts each frame.
REQ-016 Mode 2 (GRADIENT) SHALL output:
- r = low COLOR_W bits of (h_count + frame_cnt), wrapping modulo 2^COLOR_W.
- g = low COLOR_W bits of v_count.
- b = frame_cnt, zero-extended or truncated to COLOR_W.
REQ-017 Mode 3 (SOLID) SHALL output the latched solid_rgb.
REQ-018 When delayed de=0, read_r/g/b SHALL be 0 regardless of mode.
REQ-019 Pixels with h_count>=H_ACTIVE or v_count>=V_ACTIVE SHALL output 0 even when de=1.

Reset
REQ-020 On reset assertion, the following SHALL clear to 0 asynchronously:
- read_r, read_g, read_b, out_de.
- All pipeline registers and frame_cnt.
- The active mode (BARS) and the active solid colour.
REQ-021 A reset mid-frame SHALL output zeros until de and valid pixels re-enter the pipeline. The first frame_start after reset SHALL set frame_cnt to 1.

Configuration
REQ-022 Macro VPG_MARKER_EN SHALL control alignment markers.
REQ-023 With VPG_MARKER_EN defined, the markers SHALL override every mode at pixels that are active, in range and have de=1:
- (0,0) red.
- (H_ACTIVE-1,0) green.
- (0,V_ACTIVE-1) blue.
- (H_ACTIVE-1,V_ACTIVE-1) yellow.
REQ-024 Without VPG_MARKER_EN, no override logic SHALL be synthesised and mode output SHALL be unmodified.

Structure
REQ-025 Package vpg_pkg SHALL hold the following, shared with the timing generator:
- The mode enum: BARS=0, CHECKER=1, GRADIENT=2, SOLID=3.
- The 8-entry bar colour table.
- Default H_ACTIVE/V_ACTIVE constants.
REQ-026 Sub-module vpg_bar_index SHALL map h_count to a 3-bit bar index plus an out-of-range flag, using parameter-derived thresholds with no divider.

Verification
REQ-027 Reset then frame_start with mode_sel=0, de=1, v=0, h=0 and h=240 (H_ACTIVE=1920) -> 2 cycles later white, then yellow (FF,FF,00). out_de=1 aligned.
REQ-028 mode_sel changed 0->3 mid-frame with no frame_start -> output stays bars. On next frame_start with solid_rgb=0x123456 -> subsequent pixels read 12/34/56.
REQ-029 Mode 2, frame_cnt=5, h=253, v=7 -> r=0x02 (wrap), g=0x07, b=0x05. 2^FRAME_W frame_start pulses -> frame_cnt returns to 0.
REQ-030 Mode 1, CHECK_LOG2=5: pixel (32,0) frame 0 -> black; same pixel next frame -> white. Pixel (2000,0) with de=1 -> 0.
REQ-031 Reset asserted with de=1 and a valid pattern in flight -> outputs 0 immediately (asynchronously) and through release.
REQ-032 With VPG_MARKER_EN defined, mode 3 solid grey -> (0,0) red, (1919,1079) yellow, (1,0) grey. Without the macro -> (0,0) grey.
